flash_cmd_sequencer: RTL and testbench

// - Sequences SPI NOR flash operations (read word, program word, sector erase) as APB transfers to the APB-to-SPI flash controller.
// - Sits between one requester (CPU or DMA) and the controller's APB slave port.
// - Inserts WREN before program/erase and polls RDSR until WIP clears, so requesters only see one request/response per operation.

---
 rtl/flash_seq_pkg.sv | 70 +++++++
 rtl/flash_seq_apb_xfer.sv | 55 +++++
 rtl/flash_cmd_sequencer.sv | 173 +++++++++++++++++
 tb/tb_flash_cmd_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_seq_pkg.sv
// Shared definitions for the SPI NOR flash command sequencer.
// Opcodes, request ops, FSM states and step encoding.
package flash_seq_pkg;

    localparam logic [7:0] OPC_READ = 8'h03;
    localparam logic [7:0] OPC_PP   = 8'h02;
    localparam logic [7:0] OPC_WREN = 8'h06;
    localparam logic [7:0] OPC_SE   = 8'h20;
    localparam logic [7:0] OPC_RDSR = 8'h05;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_PWAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_e;

    typedef enum logic [2:0] {
        STEP_READ,
        STEP_WREN,
        STEP_PP,
        STEP_SE,
        STEP_RDSR
    } step_e;

    // Program/erase run WREN, the command, then RDSR polling at index 2.
    function automatic step_e step_of(op_e op, logic [1:0] idx);
        step_e s;
        s = STEP_RDSR;
        if (op == OP_READ)
            s = STEP_READ;
        else if (idx == 2'd0)
            s = STEP_WREN;
        else if (idx == 2'd1)
            s = (op == OP_PROGRAM) ? STEP_PP : STEP_SE;
        return s;
    endfunction

    function automatic logic [7:0] step_opc(step_e s);
        logic [7:0] o;
        case (s)
            STEP_READ: o = OPC_READ;
            STEP_WREN: o = OPC_WREN;
            STEP_PP:   o = OPC_PP;
            STEP_SE:   o = OPC_SE;
            default:   o = OPC_RDSR;
        endcase
        return o;
    endfunction

    function automatic logic step_wr(step_e s);
        return (s == STEP_WREN) || (s == STEP_PP) || (s == STEP_SE);
    endfunction

endpackage

// File: rtl/flash_seq_apb_xfer.sv
// Single APB transfer engine: one SETUP cycle then one ACCESS cycle.
// Address/control/data are latched on start and held for the transfer.
import flash_seq_pkg::*;

module flash_seq_apb_xfer (
    input  logic        p_clk,
    input  logic        p_rst,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [31:0] prdata,
    output logic        psel,
    output logic        penable,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic        done,
    output logic [31:0] rdata
);

    xfer_e phase, phase_nxt;

    always_comb begin
        phase_nxt = phase;
        unique case (phase)
            X_IDLE:   if (start) phase_nxt = X_SETUP;
            X_SETUP:  phase_nxt = X_ACCESS;
            X_ACCESS: phase_nxt = start ? X_SETUP : X_IDLE;
            default:  phase_nxt = X_IDLE;
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            phase  <= X_IDLE;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
        end else begin
            phase <= phase_nxt;
            if (start) begin
                paddr  <= addr;
                pwrite <= write;
                pwdata <= wdata;
            end
        end
    end

    assign psel    = (phase != X_IDLE);
    assign penable = (phase == X_ACCESS);
    assign done    = (phase == X_ACCESS);
    assign rdata   = prdata;

endmodule

// File: rtl/flash_cmd_sequencer.sv
// SPI NOR flash operation sequencer: expands READ/PROGRAM/ERASE requests
// into APB transfers, adding WREN and RDSR polling as needed.
import flash_seq_pkg::*;

module flash_cmd_sequencer #(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  logic        p_clk,
    input  logic        p_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] m_paddr,
    output logic        m_pwrite,
    output logic        m_psel,
    output logic        m_penable,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata
);

    localparam logic [10:0] POLL_LIM = 11'(POLL_MAX);
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_e      state, state_nxt;
    op_e         op_q, cur_op;
    logic [23:0] addr_q, cur_hi;
    logic [31:0] wdata_q, cur_wd;
    logic [1:0]  idx_q, idx_nxt;
    logic [10:0] poll_q, poll_inc;
    logic [15:0] gap_q;
    logic [31:0] rdata_q, resp_data;
    logic        err_q, resp_err, resp_load;
    logic        accept, start;
    step_e       step_cur, start_step;
    logic [31:0] x_addr, x_wdata, x_rdata;
    logic        x_write, x_done;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[7:0];

    assign accept   = req_valid && (state == S_IDLE);
    assign cur_op   = (state == S_IDLE) ? op_e'(req_op) : op_q;
    assign cur_hi   = (state == S_IDLE) ? req_addr[31:8] : addr_q;
    assign cur_wd   = (state == S_IDLE) ? req_wdata : wdata_q;
    assign step_cur = step_of(op_q, idx_q);
    assign poll_inc = poll_q + 11'd1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        start     = 1'b0;
        resp_load = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cur_op == OP_RSVD) begin
                        state_nxt = S_RESP;
                        resp_load = 1'b1;
                        resp_err  = 1'b1;
                    end else begin
                        state_nxt = S_SETUP;
                        start     = 1'b1;
                        idx_nxt   = 2'd0;
                    end
                end
            end
            S_SETUP: state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (x_done) begin
                    if (step_cur == STEP_RDSR) begin
                        if (!x_rdata[0]) begin
                            state_nxt = S_RESP;
                            resp_load = 1'b1;
                        end else if (poll_inc == POLL_LIM) begin
                            state_nxt = S_RESP;
                            resp_load = 1'b1;
                            resp_err  = 1'b1;
                        end else begin
                            state_nxt = S_PWAIT;
                        end
                    end else if (step_cur == STEP_READ) begin
                        state_nxt = S_RESP;
                        resp_load = 1'b1;
                        resp_data = x_rdata;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_nxt = S_SETUP;
                start     = 1'b1;
                idx_nxt   = idx_q + 2'd1;
            end
            S_PWAIT: begin
                if (gap_q == GAP_LAST) begin
                    state_nxt = S_SETUP;
                    start     = 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        start_step = step_of(cur_op, idx_nxt);
    end

    assign x_addr  = {cur_hi, step_opc(start_step)};
    assign x_write = step_wr(start_step);
    assign x_wdata = (start_step == STEP_PP) ? cur_wd : 32'd0;

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state   <= S_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            poll_q  <= '0;
            gap_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx_q <= idx_nxt;
            gap_q <= (state == S_PWAIT) ? gap_q + 16'd1 : 16'd0;
            if (accept) begin
                op_q    <= op_e'(req_op);
                addr_q  <= req_addr[31:8];
                wdata_q <= req_wdata;
                poll_q  <= '0;
            end else if (state == S_ACCESS && step_cur == STEP_RDSR) begin
                poll_q <= poll_inc;
            end
            if (resp_load) begin
                rdata_q <= resp_data;
                err_q   <= resp_err;
            end
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;

    flash_seq_apb_xfer u_xfer (
        .p_clk   (p_clk),
        .p_rst   (p_rst),
        .start   (start),
        .addr    (x_addr),
        .write   (x_write),
        .wdata   (x_wdata),
        .prdata  (m_prdata),
        .psel    (m_psel),
        .penable (m_penable),
        .paddr   (m_paddr),
        .pwrite  (m_pwrite),
        .pwdata  (m_pwdata),
        .done    (x_done),
        .rdata   (x_rdata)
    );

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Testbench for flash_cmd_sequencer: per-cycle expected trace built
// from the operation step rules, plus literal timing/address pins.
module tb_flash_cmd_sequencer;

    localparam int PMAX = 4;
    localparam int PGAP = 4;

    logic        p_clk = 1'b0;
    logic        p_rst = 1'b1;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] m_paddr, m_pwdata, m_prdata;
    logic        m_pwrite, m_psel, m_penable;

    always #5 p_clk = ~p_clk;

    flash_cmd_sequencer #(.POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
        .p_clk     (p_clk),
        .p_rst     (p_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .m_paddr   (m_paddr),
        .m_pwrite  (m_pwrite),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata)
    );

    typedef struct packed {
        logic        psel, pen, pwrite, cw, rsp, err, ready, busy, zero;
        logic [31:0] paddr, pwdata, prdata, rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mon_addr[$];
    int          checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
    int          mon_rsp_cyc = 0, mon_setup_cyc = 0, mon_rsp_n = 0;
    logic [31:0] mon_rdata = 0;
    logic        mon_err = 0;

    always @(posedge p_clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: one expected entry per cycle
    always @(negedge p_clk) begin : cmp
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("psel", 32'(m_psel), 32'(e.psel));
            chk("penable", 32'(m_penable), 32'(e.pen));
            chk("req_ready", 32'(req_ready), 32'(e.ready));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(e.rsp));
            if (e.psel) begin
                chk("paddr", m_paddr, e.paddr);
                chk("pwrite", 32'(m_pwrite), 32'(e.pwrite));
            end
            if (e.cw) chk("pwdata", m_pwdata, e.pwdata);
            if (e.rsp) begin
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            if (e.zero) begin
                chk("rst_paddr", m_paddr, 32'd0);
                chk("rst_pwdata", m_pwdata, 32'd0);
                chk("rst_rdata", rsp_rdata, 32'd0);
                chk("rst_pwrite", 32'(m_pwrite), 32'd0);
                chk("rst_err", 32'(rsp_err), 32'd0);
            end
            if (m_psel && !m_penable) begin
                if (mon_addr.size() == 0) mon_setup_cyc = cyc;
                mon_addr.push_back(m_paddr);
            end
            if (rsp_valid) begin
                mon_rsp_n++;
                mon_rsp_cyc = cyc;
                mon_rdata   = rsp_rdata;
                mon_err     = rsp_err;
            end
        end
    end

    function automatic exp_t mk_idle();
        exp_t e = '0;
        e.ready  = 1'b1;
        e.prdata = $urandom;
        return e;
    endfunction

    function automatic exp_t mk_rst();
        exp_t e = mk_idle();
        e.zero = 1'b1;
        return e;
    endfunction

    function automatic exp_t mk_busy();
        exp_t e = '0;
        e.busy   = 1'b1;
        e.prdata = $urandom;
        return e;
    endfunction

    function automatic exp_t mk_xf(logic [31:0] pa, logic wr, logic pen,
                                   logic cw, logic [31:0] wd, logic [31:0] pr);
        exp_t e = mk_busy();
        e.psel   = 1'b1;
        e.pen    = pen;
        e.paddr  = pa;
        e.pwrite = wr;
        e.cw     = cw;
        e.pwdata = wd;
        if (pen) e.prdata = pr;
        return e;
    endfunction

    function automatic exp_t mk_resp(logic [31:0] rd, logic err);
        exp_t e = mk_busy();
        e.rsp   = 1'b1;
        e.rdata = rd;
        e.err   = err;
        return e;
    endfunction

    task automatic junk(input logic v);
        req_valid = v;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic tick(input exp_t e);
        m_prdata = e.prdata;
        exp_q.push_back(e);
        @(posedge p_clk);
        #1;
    endtask

    // mode: 0 random WIP, 1 WIP stuck, 2 status 1,1,0, 3 clear on first poll
    task automatic do_op(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdv,
                         input int idle, input int mode, input int rst_at,
                         input logic hold);
        exp_t        tr[$];
        logic [31:0] hi, st;
        logic [7:0]  opc2;
        logic        err;
        hi = {addr[31:8], 8'h00};
        if (op == 2'd0) begin
            tr.push_back(mk_xf(hi | 32'h03, 1'b0, 1'b0, 1'b0, 0, 0));
            tr.push_back(mk_xf(hi | 32'h03, 1'b0, 1'b1, 1'b0, 0, rdv));
            tr.push_back(mk_resp(rdv, 1'b0));
        end else if (op == 2'd3) begin
            tr.push_back(mk_resp(32'd0, 1'b1));
        end else begin
            opc2 = (op == 2'd1) ? 8'h02 : 8'h20;
            tr.push_back(mk_xf(hi | 32'h06, 1'b1, 1'b0, 1'b0, 0, 0));
            tr.push_back(mk_xf(hi | 32'h06, 1'b1, 1'b1, 1'b0, 0, 0));
            tr.push_back(mk_busy());
            tr.push_back(mk_xf(hi | {24'h0, opc2}, 1'b1, 1'b0, op == 2'd1, wd, 0));
            tr.push_back(mk_xf(hi | {24'h0, opc2}, 1'b1, 1'b1, op == 2'd1, wd, 0));
            tr.push_back(mk_busy());
            err = 1'b1;
            for (int p = 1; p <= PMAX; p++) begin
                st = $urandom;
                case (mode)
                    0: st[0] = ($urandom_range(0, 2) != 0);
                    1: st[0] = 1'b1;
                    2: st = (p < 3) ? 32'h1 : 32'h0;
                    default: st[0] = 1'b0;
                endcase
                tr.push_back(mk_xf(hi | 32'h05, 1'b0, 1'b0, 1'b0, 0, 0));
                tr.push_back(mk_xf(hi | 32'h05, 1'b0, 1'b1, 1'b0, 0, st));
                if (!st[0]) begin
                    err = 1'b0;
                    break;
                end
                if (p < PMAX) repeat (PGAP) tr.push_back(mk_busy());
            end
            tr.push_back(mk_resp(32'd0, err));
        end
        repeat (idle) begin
            junk(1'b0);
            tick(mk_idle());
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        mon_addr.delete();
        mon_rsp_n = 0;
        acc_cyc   = cyc;
        tick(mk_idle());
        foreach (tr[i]) begin
            junk(hold ? 1'b1 : 1'($urandom));
            if (i == rst_at) begin
                p_rst = 1'b1;
                junk(1'b0);
                tick(tr[i]);
                tick(mk_rst());
                p_rst = 1'b0;
                tick(mk_rst());
                return;
            end
            tick(tr[i]);
        end
    endtask

    initial begin
        int r1, nr;
        logic [31:0] pexp[5];
        junk(1'b0);
        m_prdata = 32'd0;
        p_rst    = 1'b1;
        @(posedge p_clk);
        #1;
        tick(mk_rst());
        p_rst = 1'b0;
        tick(mk_rst());

        do_op(2'd0, 32'h00012300, 32'd0, 32'hDEADBEEF, 1, 0, -1, 1'b0);
        chk("read_setup_cyc", 32'(mon_setup_cyc - acc_cyc), 32'd1);
        chk("read_rsp_cyc", 32'(mon_rsp_cyc - acc_cyc), 32'd3);
        chk("read_rdata", mon_rdata, 32'hDEADBEEF);
        chk("read_err", 32'(mon_err), 32'd0);
        chk("read_nxfer", 32'(mon_addr.size()), 32'd1);
        chk("read_paddr", mon_addr[0], 32'h00012303);

        do_op(2'd1, 32'h00000400, 32'hA5A5A5A5, 32'd0, 2, 2, -1, 1'b0);
        pexp = '{32'h406, 32'h402, 32'h405, 32'h405, 32'h405};
        chk("prog_nxfer", 32'(mon_addr.size()), 32'd5);
        foreach (pexp[i]) chk("prog_paddr_seq", mon_addr[i], pexp[i]);
        // 6 (WREN,PP with gaps) + 3 polls + 2 poll gaps of 4 -> rsp at c21
        chk("prog_rsp_cyc", 32'(mon_rsp_cyc - acc_cyc), 32'd21);
        chk("prog_err", 32'(mon_err), 32'd0);
        chk("prog_rdata", mon_rdata, 32'd0);

        do_op(2'd2, 32'h00ABCD55, 32'd0, 32'd0, 0, 1, -1, 1'b0);
        nr = 0;
        foreach (mon_addr[i]) if (mon_addr[i][7:0] == 8'h05) nr++;
        chk("erase_nrdsr", 32'(nr), 32'd4);
        chk("erase_nxfer", 32'(mon_addr.size()), 32'd6);
        chk("erase_err", 32'(mon_err), 32'd1);
        chk("erase_rsp_cyc", 32'(mon_rsp_cyc - acc_cyc), 32'd27);

        do_op(2'd1, 32'h00FF0000, 32'h12345678, 32'd0, 1, 3, -1, 1'b0);
        chk("prog_fast_rsp_cyc", 32'(mon_rsp_cyc - acc_cyc), 32'd9);

        do_op(2'd3, 32'h11111111, 32'd0, 32'd0, 1, 0, -1, 1'b0);
        chk("rsvd_rsp_cyc", 32'(mon_rsp_cyc - acc_cyc), 32'd1);
        chk("rsvd_err", 32'(mon_err), 32'd1);
        chk("rsvd_nxfer", 32'(mon_addr.size()), 32'd0);

        do_op(2'd1, 32'h00002000, 32'hCAFEF00D, 32'd0, 1, 0, 4, 1'b1);
        chk("rst_no_rsp", 32'(mon_rsp_n), 32'd0);
        chk("rst_nxfer", 32'(mon_addr.size()), 32'd2);
        do_op(2'd0, 32'h00003300, 32'd0, 32'h0BADCAFE, 0, 0, -1, 1'b0);
        chk("rst_recover_rdata", mon_rdata, 32'h0BADCAFE);

        do_op(2'd0, 32'h00044400, 32'd0, 32'h11223344, 1, 0, -1, 1'b1);
        r1 = mon_rsp_cyc;
        do_op(2'd0, 32'h00055500, 32'd0, 32'h55667788, 0, 0, -1, 1'b1);
        chk("b2b_spacing", 32'(mon_rsp_cyc - r1), 32'd4);
        chk("b2b_rdata", mon_rdata, 32'h55667788);

        repeat (60) begin
            do_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), 0, -1, 1'($urandom_range(0, 1)));
        end

        junk(1'b0);
        tick(mk_idle());
        tick(mk_idle());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
